// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory arbiter slice.
//   arb_state_t  : arbiter FSM states (IDLE, ISSUE, RESP)
//   DEF_*        : default geometry used as parameter defaults by mem_arbiter
//   REQ_*        : requester index assignment (index 0 has top fixed priority)
// Optional feature macro used by this slice: MEM_ARB_RR_EN (round-robin).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int DEF_N_REQ  = 3;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    localparam int REQ_LOADER = 0;
    localparam int REQ_DATA   = 1;
    localparam int REQ_FETCH  = 2;

    // Width of a requester index; never zero so single-requester builds still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational picker: searches the request vector starting at 'base' and
// wrapping from N_REQ-1 back to 0; the first requester found wins.
// Ports:
//   req     in   N_REQ   request vector
//   base    in   IDX_W   index where the search starts (0 = fixed priority)
//   onehot  out  N_REQ   one-hot winner, all zero when nothing requests
//   idx     out  IDX_W   binary winner index, 0 when nothing requests
//   valid   out  1       a winner exists
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = idx_width(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] base,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin : search
        int cand;
        // NOTE: every output gets a default before the loop so no path leaves a
        // value unassigned; otherwise synthesis infers latches.
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(base) + k) % N_REQ;
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = IDX_W'(cand);
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one synchronous single-port RAM (1-cycle registered read) between
// N_REQ requesters. One access per grant; a request sampled at edge T gives
// gnt and the RAM access in cycle T+1, and done (plus read data) in T+2.
// Arbitration: fixed priority (index 0 wins) by default; round-robin starting
// after the last winner when MEM_ARB_RR_EN is defined.
// Ports:
//   clock      in   1             rising-edge clock
//   reset      in   1             synchronous, active-high
//   req        in   N_REQ         request per requester, held until gnt
//   we         in   N_REQ         1 = write, 0 = read
//   addr       in   N_REQ*ADDR_W  packed request addresses
//   wdata      in   N_REQ*DATA_W  packed write data
//   gnt        out  N_REQ         one-hot pulse: request accepted (ISSUE)
//   done       out  N_REQ         one-hot pulse: access complete (RESP)
//   rdata      out  DATA_W        read data, valid with done of a read
//   mem_en     out  1             RAM enable
//   mem_we     out  1             RAM write enable
//   mem_addr   out  ADDR_W        RAM address
//   mem_wdata  out  DATA_W        RAM write data
//   mem_rdata  in   DATA_W        RAM read data, valid 1 cycle after mem_en
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         we,
    input  logic [N_REQ*ADDR_W-1:0]  addr,
    input  logic [N_REQ*DATA_W-1:0]  wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_t        state, state_nx;
    logic              load;

    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [IDX_W-1:0]  base;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Request latched at grant; drives the RAM in ISSUE and gnt/done.
    logic [N_REQ-1:0]  win_oh_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    // -----------------------------------------------------------------------
    // Search base: rotating pointer in round-robin mode, constant 0 otherwise.
    // -----------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
    logic [IDX_W-1:0] last_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= '0;
        end else if (load) begin
            last_q <= pick_idx;
        end
    end

    // Start one past the last winner, wrapping N_REQ-1 -> 0.
    always_comb begin
        base = (int'(last_q) >= N_REQ - 1) ? '0 : last_q + IDX_W'(1);
    end
`else
    always_comb begin
        base = '0;
    end
`endif

    mem_arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .base   (base),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Select the winning requester's command fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and outputs. Arbitration only takes effect from IDLE or
    // RESP, so req activity during ISSUE is ignored.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        gnt       = '0;
        done      = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nx = ISSUE;
                    load     = 1'b1;
                end
            end
            ISSUE: begin
                state_nx  = RESP;
                gnt       = win_oh_q;
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                done = win_oh_q;
                if (pick_valid) begin
                    state_nx = ISSUE;
                    load     = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The RAM data is presented straight through during the read's RESP cycle
    // so it lines up with done, and is captured at the end of that cycle so
    // it holds afterwards (including across writes).
    always_comb begin
        rdata = (state == RESP && !we_q) ? mem_rdata : rdata_q;
    end

    // -----------------------------------------------------------------------
    // State and latched request.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, whatever order the statements are written in.
            state    <= IDLE;
            win_oh_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                win_oh_q <= pick_oh;
                we_q     <= sel_we;
                addr_q   <= sel_addr;
                wdata_q  <= sel_wdata;
            end
            if (state == RESP && !we_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter (N_REQ=3, 8-bit address and data).
// A RAM model answers the memory port; a transaction-level reference model
// (shadow memory, priority/rotation rule, 1-cycle grant / 2-cycle spacing
// rule) predicts every gnt, done, memory command and rdata value.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int N = 3;
    localparam int AW = 8;
    localparam int DW = 8;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [DW-1:0]  rdata;
    logic           mem_en;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    always #5 clock = ~clock;

    mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous RAM with registered read data.
    logic [DW-1:0] ram [256];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // Reference model state.
    logic [DW-1:0] sh [256];     // expected memory contents
    logic [DW-1:0] model_rdata;  // value rdata must hold between read completions
    int            mlw;          // last granted requester
    int            cnt [N];      // grants still wanted per requester

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: lowest index wins, or in round-robin mode the first
    // requester found searching upward from one past the last winner.
    function automatic int model_pick(input logic [N-1:0] p);
`ifdef MEM_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            int c = (mlw + k) % N;
            if (p[c]) return c;
        end
`else
        for (int c = 0; c < N; c++) begin
            if (p[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},    32'(gnt), 0);
        check({tag, "_done"},   32'(done), 0);
        check({tag, "_mem_en"}, 32'(mem_en), 0);
        check({tag, "_rdata"},  32'(rdata), 32'(model_rdata));
    endtask

    // Raise the requests in 'mask' (call at a falling edge) and follow them
    // until every requester has received cnt[i] grants and the last done.
    task automatic run_batch(input string tag, input logic [N-1:0] mask);
        int      cyc = 0;
        int      last_gnt = -1;
        logic    pend_done = 1'b0;
        int      pend_idx = 0;
        logic    pend_rd = 1'b0;
        logic [DW-1:0] pend_val = '0;
        req = mask;
        while ((req != '0 || pend_done) && cyc < 60) begin
            @(negedge clock);
            cyc++;
            check({tag, "_gnt_onehot"}, 32'($countones(gnt) <= 1), 1);
            check({tag, "_gnt_done_overlap"}, 32'(gnt & done), 0);
            if (pend_done) begin
                check({tag, "_done"}, 32'(done), 32'(1 << pend_idx));
                if (pend_rd) model_rdata = pend_val;
                check({tag, "_rdata_at_done"}, 32'(rdata), 32'(model_rdata));
                pend_done = 1'b0;
            end else begin
                check({tag, "_no_done"}, 32'(done), 0);
                check({tag, "_rdata_hold"}, 32'(rdata), 32'(model_rdata));
            end
            if (req != '0 && ((last_gnt < 0) ? (cyc == 1) : (cyc == last_gnt + 2))) begin
                int w = model_pick(req);
                logic [AW-1:0] a = addr[w*AW +: AW];
                check({tag, "_gnt"},      32'(gnt), 32'(1 << w));
                check({tag, "_mem_en"},   32'(mem_en), 1);
                check({tag, "_mem_we"},   32'(mem_we), 32'(we[w]));
                check({tag, "_mem_addr"}, 32'(mem_addr), 32'(a));
                if (we[w]) begin
                    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(wdata[w*DW +: DW]));
                    sh[a] = wdata[w*DW +: DW];
                end
                mlw       = w;
                pend_done = 1'b1;
                pend_idx  = w;
                pend_rd   = !we[w];
                pend_val  = sh[a];
                last_gnt  = cyc;
                cnt[w]--;
                if (cnt[w] <= 0) req[w] = 1'b0;
            end else begin
                check({tag, "_no_gnt"}, 32'(gnt), 0);
                check({tag, "_mem_en_low"}, 32'(mem_en), 0);
            end
        end
        check({tag, "_timeout"}, 32'(req != '0 || pend_done), 0);
        req = '0;
        @(negedge clock);
        check_idle({tag, "_after"});
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int c);
        we[i]              = w;
        addr[i*AW +: AW]   = a;
        wdata[i*DW +: DW]  = d;
        cnt[i]             = c;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        mlw   = 0;
        model_rdata = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'($urandom);
            sh[i]  = ram[i];
        end
        ram[8'h10] = 8'hA5;
        sh[8'h10]  = 8'hA5;

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_gnt",       32'(gnt), 0);
        check("rst_done",      32'(done), 0);
        check("rst_rdata",     32'(rdata), 0);
        check("rst_mem_en",    32'(mem_en), 0);
        check("rst_mem_we",    32'(mem_we), 0);
        check("rst_mem_addr",  32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        reset = 1'b0;
        @(negedge clock);

        // Single read from the fetch port.
        set_req(2, 1'b0, 8'h10, 8'h00, 1);
        run_batch("single_read", 3'b100);
        check("single_read_value", 32'(model_rdata), 32'h A5);

        // Write then read back through the data port.
        set_req(1, 1'b1, 8'h20, 8'h3C, 1);
        run_batch("write", 3'b010);
        set_req(1, 1'b0, 8'h20, 8'h00, 1);
        run_batch("readback", 3'b010);
        check("readback_value", 32'(rdata), 32'h3C);

        // Contention: loader wants three grants, the others one each.
        set_req(0, 1'b0, 8'h01, 8'h00, 3);
        set_req(1, 1'b0, 8'h02, 8'h00, 1);
        set_req(2, 1'b0, 8'h03, 8'h00, 1);
        run_batch("contention", 3'b111);

        // Back-to-back grants two cycles apart.
        set_req(1, 1'b1, 8'h44, 8'h5A, 1);
        set_req(2, 1'b0, 8'h44, 8'h00, 1);
        run_batch("back_to_back", 3'b110);

        // Reset asserted in the ISSUE cycle abandons the access.
        set_req(1, 1'b0, 8'h40, 8'h00, 0);
        req = 3'b010;
        @(negedge clock);
        check("rst_mid_gnt", 32'(gnt), 32'b010);
        reset = 1'b1;
        req   = '0;
        @(negedge clock);
        model_rdata = '0;
        mlw   = 0;
        check("rst_mid_gnt_after",   32'(gnt), 0);
        check("rst_mid_done_after",  32'(done), 0);
        check("rst_mid_mem_en",      32'(mem_en), 0);
        check("rst_mid_mem_addr",    32'(mem_addr), 0);
        check("rst_mid_rdata",       32'(rdata), 0);
        reset = 1'b0;
        @(negedge clock);
        check_idle("rst_mid_no_done");
        set_req(2, 1'b0, 8'h10, 8'h00, 1);
        run_batch("after_reset", 3'b100);

        // Request raised only during ISSUE and dropped again is never granted.
        set_req(0, 1'b0, 8'h33, 8'h00, 1);
        req = 3'b001;
        @(negedge clock);
        check("withdraw_gnt0", 32'(gnt), 32'b001);
        mlw = 0;
        req = 3'b100;
        @(negedge clock);
        model_rdata = sh[8'h33];
        check("withdraw_done0", 32'(done), 32'b001);
        check("withdraw_rdata", 32'(rdata), 32'(model_rdata));
        req = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_idle("withdraw_idle");
        end

        // Randomized batches.
        for (int b = 0; b < 25; b++) begin
            logic [N-1:0] m = N'($urandom_range(1, 7));
            for (int i = 0; i < N; i++) begin
                set_req(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                        m[i] ? int'($urandom_range(1, 2)) : 0);
            end
            run_batch("random", m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
